serv_dbus_ram: RTL and testbench

Wishbone classic data-bus responder for the bit-serial core's memory interface. Accepts the 32-bit word-addressed read/write requests, with byte selects, that the core's memory interface issues. Serves them from an internal byte-laned RAM with a configurable number of wait states and a single-cycle acknowledge. Sits on the far side of the core's dbus, standing in for data memory in small SoCs and in the core's test benches.

---
 rtl/serv_dbus_ram.sv | 142 ++++++++++++++
 tb/tb_serv_dbus_ram.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_ram.sv
// Wishbone classic data-bus RAM responder for the bit-serial core, with configurable wait states.
// Define SERV_DBUS_ERR_EN to get an error pulse on out-of-range addresses or illegal byte selects.
module serv_dbus_ram #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int unsigned WORDS = DEPTH / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          err_q;

  logic [31:0]   mem [WORDS];

  logic          chk_err_c;
  logic [31:0]   req_adr_c;
  logic [31:0]   req_dat_c;
  logic [3:0]    req_sel_c;
  logic          req_we_c;
  logic          req_err_c;
  logic          to_resp_c;
  logic [IW-1:0] idx_c;
  logic          mem_we_c;

  // Request legality, evaluated only when a request is latched in IDLE
`ifdef SERV_DBUS_ERR_EN
  always_comb begin
    chk_err_c = (i_wb_adr >= 32'(DEPTH));
    case (i_wb_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: ;
      default: chk_err_c = 1'b1;
    endcase
  end
`else
  assign chk_err_c = 1'b0;
`endif

  // With zero wait states the request completes on its acceptance edge, so use the live bus
  always_comb begin
    req_adr_c = adr_q;
    req_dat_c = dat_q;
    req_sel_c = sel_q;
    req_we_c  = we_q;
    req_err_c = err_q;
    to_resp_c = 1'b0;
    if (state_q == IDLE) begin
      req_adr_c = i_wb_adr;
      req_dat_c = i_wb_dat;
      req_sel_c = i_wb_sel;
      req_we_c  = i_wb_we;
      req_err_c = chk_err_c;
      to_resp_c = i_wb_cyc && (WAIT_STATES == 0);
    end else if (state_q == WAIT) begin
      to_resp_c = i_wb_cyc && (cnt_q == CW'(1));
    end
    idx_c    = IW'((req_adr_c >> 2) & 32'(WORDS - 1));
    mem_we_c = to_resp_c && req_we_c && !req_err_c && i_rst_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      o_wb_rdt <= '0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_wb_cyc) begin
            adr_q   <= i_wb_adr;
            dat_q   <= i_wb_dat;
            sel_q   <= i_wb_sel;
            we_q    <= i_wb_we;
            err_q   <= chk_err_c;
            cnt_q   <= CW'(WAIT_STATES);
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (!i_wb_cyc) begin
            state_q <= IDLE;
          end else if (cnt_q == CW'(1)) begin
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (to_resp_c) begin
        if (req_err_c) begin
          o_wb_err <= 1'b1;
        end else begin
          o_wb_ack <= 1'b1;
          if (!req_we_c) begin
            o_wb_rdt <= mem[idx_c];
          end
        end
      end
    end
  end

  // Byte-laned storage, deliberately not reset
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel_c[b]) begin
          mem[idx_c][8*b +: 8] <= req_dat_c[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_serv_dbus_ram.sv
// Self-checking bench for serv_dbus_ram: two instances (0 and 3 wait states) against an array model.
module tb_serv_dbus_ram;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WORDS = DEPTH / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0]  sel [2];
  logic        we  [2];
  logic        cyc [2];
  logic [31:0] rdt [2];
  logic        ack [2];
  logic        err [2];

  always #5 clk = ~clk;

  serv_dbus_ram #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .i_wb_sel(sel[0]),
    .i_wb_we(we[0]), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0])
  );

  serv_dbus_ram #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .i_wb_sel(sel[1]),
    .i_wb_we(we[1]), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1])
  );

  int          passed = 0;
  int          total  = 0;
  logic [31:0] model [2][WORDS];
  logic [31:0] last_rdt [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  function automatic logic is_err(input logic [31:0] a, input logic [3:0] s);
`ifdef SERV_DBUS_ERR_EN
    return (a >= DEPTH) || !(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete transaction: drive, wait for completion, check timing/response/data, release
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] dt,
                     input logic [3:0] s, input logic w);
    int   n;
    logic e;
    e = is_err(a, s);
    adr[d] = a; dat[d] = dt; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 20);
    check($sformatf("latency d%0d a%h", d, a), 32'(n), 32'(ws_of(d) + 1));
    check($sformatf("ack d%0d a%h", d, a), 32'(ack[d]), 32'(!e));
    check($sformatf("err d%0d a%h", d, a), 32'(err[d]), 32'(e));
    if (!e && !w) last_rdt[d] = model[d][widx(a)];
    check($sformatf("rdt d%0d a%h we%0d", d, a, w), rdt[d], last_rdt[d]);
    if (!e && w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[d][widx(a)][8*b +: 8] = dt[8*b +: 8];
    end
    cyc[d] = 1'b0;
    @(negedge clk);
    check($sformatf("pulse d%0d a%h", d, a), 32'(ack[d] | err[d]), 32'h0);
  endtask

  initial begin
    int          n;
    logic        got_ack;
    logic [31:0] a;
    logic [31:0] old;

    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; dat[d] = '0; sel[d] = '0; we[d] = 1'b0; cyc[d] = 1'b0; last_rdt[d] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ack d%0d", d), 32'(ack[d]), 32'h0);
      check($sformatf("reset err d%0d", d), 32'(err[d]), 32'h0);
      check($sformatf("reset rdt d%0d", d), rdt[d], 32'h0);
    end
    rst_n = 1'b1;

    // Fill every word with known random data
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < int'(WORDS); i++)
        txn(d, 32'(i * 4), $urandom, 4'hF, 1'b1);

    // Full word write/read, then lane merging
    txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    txn(0, 32'h10, 32'h0, 4'hF, 1'b0);
    check("deadbeef", rdt[0], 32'hDEADBEEF);
    txn(0, 32'h20, 32'h11223344, 4'b1111, 1'b1);
    txn(0, 32'h20, 32'h0000AA00, 4'b0010, 1'b1);
    txn(0, 32'h20, 32'hBBBB0000, 4'b1100, 1'b1);
    txn(0, 32'h20, 32'h0, 4'hF, 1'b0);
    check("lanes", rdt[0], 32'hBBBBAA44);

    // cyc held through RESP on the 3-wait-state instance: next ack exactly 5 cycles later
    adr[1] = 32'h0C; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[1] && n < 20);
    check("hold first latency", 32'(n), 32'd4);
    check("hold first rdt", rdt[1], model[1][3]);
    n = 0;
    do begin @(negedge clk); n++; end while (!ack[1] && n < 20);
    check("hold spacing", 32'(n), 32'd5);
    cyc[1] = 1'b0;
    @(negedge clk);
    check("hold pulse", 32'(ack[1]), 32'h0);
    last_rdt[1] = model[1][3];

    // Abort a write during wait states
    old = model[1][5];
    adr[1] = 32'h14; dat[1] = ~old; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1;
    got_ack = 1'b0;
    repeat (2) begin @(negedge clk); got_ack |= ack[1] | err[1]; end
    cyc[1] = 1'b0;
    repeat (6) begin @(negedge clk); got_ack |= ack[1] | err[1]; end
    check("abort no ack", 32'(got_ack), 32'h0);
    txn(1, 32'h14, 32'h0, 4'hF, 1'b0);
    check("abort old value", rdt[1], old);

    // Reset in the middle of a waiting write
    old = model[1][6];
    adr[1] = 32'h18; dat[1] = ~old; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset ack", 32'(ack[1]), 32'h0);
    check("midreset err", 32'(err[1]), 32'h0);
    check("midreset rdt d1", rdt[1], 32'h0);
    check("midreset rdt d0", rdt[0], 32'h0);
    cyc[1] = 1'b0;
    last_rdt[0] = '0;
    last_rdt[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 32'h18, 32'h0, 4'hF, 1'b0);
    check("midreset word kept", rdt[1], old);

    // Address beyond DEPTH and illegal select pattern
    txn(0, 32'(DEPTH + 4), 32'hCAFEF00D, 4'hF, 1'b1);
    txn(0, 32'h4, 32'h0, 4'hF, 1'b0);
    txn(0, 32'(DEPTH), 32'h0BADF00D, 4'hF, 1'b1);
    txn(0, 32'h8, 32'h12345678, 4'b0110, 1'b1);
    txn(0, 32'h8, 32'h0, 4'hF, 1'b0);

    // Randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2 * DEPTH - 1));
      txn(int'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
